// File: rtl/lease_policy_pkg.sv
// Shared definitions for the lease policy controllers: FSM encoding,
// LFSR seed, decrement-scope encodings and a constant clog2 helper.
package lease_policy_pkg;

    typedef enum logic {
        ST_NORMAL   = 1'b0,
        ST_GENERATE = 1'b1
    } state_t;

    localparam logic [11:0] LFSR_SEED = 12'hA11;

    // Decrement scope: every line, or only the lines of the accessed set.
    localparam int DEC_MODE_GLOBAL = 0;
    localparam int DEC_MODE_SET    = 1;

    function automatic int CLOG2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/lease_set_selector.sv
// Finds the expired (zero-lease) ways of one set and reports the lowest
// and highest of them.
module lease_set_selector
    import lease_policy_pkg::*;
#(
    parameter int SET_SIZE = 4,
    parameter int LEASE_BW = 24,
    localparam int BW_WAY  = CLOG2(SET_SIZE)
) (
    input  logic [SET_SIZE*LEASE_BW-1:0] leases_i,
    output logic [SET_SIZE-1:0]          expired_o,
    output logic                         valid_o,
    output logic [BW_WAY-1:0]            lowest_o,
    output logic [BW_WAY-1:0]            highest_o
);

    logic unused_high_valid;

    // One flag per way whose lease has run out.
    always_comb begin
        expired_o = '0;
        for (int w = 0; w < SET_SIZE; w++) begin
            expired_o[w] = (leases_i[w*LEASE_BW +: LEASE_BW] == '0);
        end
    end

    priority_encoder #(.WIDTH(SET_SIZE), .LSB_FIRST(1'b1)) u_lowest (
        .req_i   (expired_o),
        .idx_o   (lowest_o),
        .valid_o (valid_o)
    );

    priority_encoder #(.WIDTH(SET_SIZE), .LSB_FIRST(1'b0)) u_highest (
        .req_i   (expired_o),
        .idx_o   (highest_o),
        .valid_o (unused_high_valid)
    );

endmodule

// File: rtl/linear_shift_register_12b.sv
// 12-bit Fibonacci LFSR (taps 12,6,4,1) that advances only when stepped.
module linear_shift_register_12b
    import lease_policy_pkg::*;
(
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        step_i,
    output logic [11:0] value_o
);

    logic [11:0] lfsr_q, lfsr_d;

    // Shift left, feedback enters at bit 0.
    always_comb begin
        lfsr_d = lfsr_q;
        if (step_i) lfsr_d = {lfsr_q[10:0], lfsr_q[11] ^ lfsr_q[5] ^ lfsr_q[3] ^ lfsr_q[0]};
    end

    // State register; reset reloads the seed.
    always_ff @(posedge clock_i) begin
        if (reset_i) lfsr_q <= LFSR_SEED;
        else         lfsr_q <= lfsr_d;
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/priority_encoder.sv
// Priority encoder returning the index of the lowest (LSB_FIRST=1) or
// highest (LSB_FIRST=0) asserted request bit.
module priority_encoder
    import lease_policy_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1,
    localparam int BW       = CLOG2(WIDTH)
) (
    input  logic [WIDTH-1:0] req_i,
    output logic [BW-1:0]    idx_o,
    output logic             valid_o
);

    // Later loop iterations win, so the scan order sets the priority.
    always_comb begin
        idx_o   = '0;
        valid_o = |req_i;
        if (LSB_FIRST) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (req_i[i]) idx_o = BW'(i);
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (req_i[i]) idx_o = BW'(i);
            end
        end
    end

endmodule

// File: rtl/sa_cache_lease_policy_controller.sv
// Set-associative lease policy controller: one lease per line, victim
// chosen inside the accessed set (cold fill, lowest expired, then random).
// Handshake: miss_i/hit_i are accepted only in ST_NORMAL; after an
// allocating miss the cache controller waits for done_o before the next
// access, and done_o/swap_o/way_o hold until the following miss.
module sa_cache_lease_policy_controller
    import lease_policy_pkg::*;
#(
    parameter int CACHE_BLOCK_CAPACITY = 128,
    parameter int CACHE_SET_SIZE       = 4,
    parameter int LEASE_VALUE_BW       = 24,
    parameter int DECREMENT_MODE       = DEC_MODE_GLOBAL,
    localparam int N_SETS = CACHE_BLOCK_CAPACITY / CACHE_SET_SIZE,
    localparam int BW_SET = CLOG2(N_SETS),
    localparam int BW_WAY = CLOG2(CACHE_SET_SIZE)
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      con_wren_i,
    input  logic [31:0]               con_data_i,
    input  logic [BW_SET-1:0]         set_i,
    input  logic [BW_WAY-1:0]         way_i,
    input  logic                      hit_i,
    input  logic                      miss_i,
    input  logic                      lease_hit_i,
    input  logic [LEASE_VALUE_BW-1:0] lease_i,
    output logic                      done_o,
    output logic [BW_WAY-1:0]         way_o,
    output logic                      swap_o,
    output logic                      expired_o,
    output logic                      expired_multi_o,
    output logic                      default_o,
    output logic                      busy_o
);

    localparam int LBW = LEASE_VALUE_BW;
    localparam logic [LBW-1:0] LEASE_ONE = LBW'(1);

    state_t                     state_q, state_d;
    logic [LBW-1:0]             lease_q [CACHE_BLOCK_CAPACITY];
    logic [LBW-1:0]             default_lease_q, saved_lease_q;
    logic [BW_SET-1:0]          saved_set_q;
    logic                       followup_q;
    logic [BW_WAY-1:0]          cold_cnt_q [N_SETS];
    logic [N_SETS-1:0]          full_q;
    logic                       done_q, done_d, swap_q, swap_d;
    logic                       expired_q, expired_d, multi_q, multi_d, default_q, default_d;
    logic [BW_WAY-1:0]          way_q, way_d;

    logic [LBW-1:0]             eff_lease;
    logic                       take_miss, alloc, take_hit, fu_hit, gen_en, dec_en;
    logic [CACHE_SET_SIZE*LBW-1:0] set_leases;
    logic [CACHE_SET_SIZE-1:0]  exp_flags;
    logic                       exp_valid, exp_any, cold_sel, lfsr_step;
    logic [BW_WAY-1:0]          exp_lo, exp_hi, victim_way;
    logic [11:0]                lfsr_value;
    logic [BW_SET+BW_WAY-1:0]   hit_idx;
    logic                       unused_bits;

    assign eff_lease   = lease_hit_i ? lease_i : default_lease_q;
    assign hit_idx     = {set_i, way_i};
    assign dec_en      = take_miss | take_hit;
    assign unused_bits = &{1'b0, con_data_i, lfsr_value[0], lfsr_value[11:BW_WAY+1]};

    // Lease vector of the set latched by the allocating miss.
    always_comb begin
        set_leases = '0;
        for (int w = 0; w < CACHE_SET_SIZE; w++) begin
            set_leases[w*LBW +: LBW] = lease_q[{saved_set_q, BW_WAY'(w)}];
        end
    end

    lease_set_selector #(.SET_SIZE(CACHE_SET_SIZE), .LEASE_BW(LBW)) u_selector (
        .leases_i  (set_leases),
        .expired_o (exp_flags),
        .valid_o   (exp_valid),
        .lowest_o  (exp_lo),
        .highest_o (exp_hi)
    );

    linear_shift_register_12b u_lfsr (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .step_i  (lfsr_step),
        .value_o (lfsr_value)
    );

    // Victim priority: cold fill, lowest expired way, then pseudo-random.
    always_comb begin
        cold_sel  = ~full_q[saved_set_q];
        exp_any   = exp_valid & (|exp_flags);
        lfsr_step = gen_en & ~cold_sel & ~exp_any;
        if (cold_sel)     victim_way = cold_cnt_q[saved_set_q];
        else if (exp_any) victim_way = exp_lo;
        else              victim_way = lfsr_value[BW_WAY:1];
    end

    // Next-state and registered-output decode; miss wins over hit.
    always_comb begin
        state_d   = state_q;
        take_miss = 1'b0;
        alloc     = 1'b0;
        take_hit  = 1'b0;
        fu_hit    = 1'b0;
        gen_en    = 1'b0;
        done_d    = done_q;
        swap_d    = swap_q;
        way_d     = way_q;
        expired_d = 1'b0;
        multi_d   = 1'b0;
        default_d = 1'b0;
        case (state_q)
            ST_NORMAL: begin
                if (miss_i) begin
                    take_miss = 1'b1;
                    default_d = ~lease_hit_i;
                    if (eff_lease != '0) begin
                        alloc   = 1'b1;
                        done_d  = 1'b0;
                        swap_d  = 1'b1;
                        state_d = ST_GENERATE;
                    end else begin
                        done_d = 1'b1;
                        swap_d = 1'b0;
                    end
                end else if (hit_i) begin
                    if (followup_q) begin
                        fu_hit = 1'b1;
                    end else begin
                        take_hit  = 1'b1;
                        default_d = ~lease_hit_i;
                    end
                end
            end
            ST_GENERATE: begin
                gen_en    = 1'b1;
                done_d    = 1'b1;
                way_d     = victim_way;
                expired_d = ~cold_sel & exp_any;
                multi_d   = ~cold_sel & exp_any & (exp_lo != exp_hi);
                state_d   = ST_NORMAL;
            end
            default: state_d = ST_NORMAL;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= ST_NORMAL;
            done_q    <= 1'b0;
            swap_q    <= 1'b0;
            way_q     <= '0;
            expired_q <= 1'b0;
            multi_q   <= 1'b0;
            default_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            swap_q    <= swap_d;
            way_q     <= way_d;
            expired_q <= expired_d;
            multi_q   <= multi_d;
            default_q <= default_d;
        end
    end

    // Lease registers: saturating decrement in scope, then the hit write wins.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < CACHE_BLOCK_CAPACITY; i++) lease_q[i] <= '0;
        end else begin
            for (int i = 0; i < CACHE_BLOCK_CAPACITY; i++) begin
                if (dec_en && lease_q[i] != '0 &&
                    ((DECREMENT_MODE == DEC_MODE_GLOBAL) || ((i / CACHE_SET_SIZE) == int'(set_i))))
                    lease_q[i] <= lease_q[i] - LEASE_ONE;
            end
            if (take_hit)    lease_q[hit_idx] <= eff_lease;
            else if (fu_hit) lease_q[hit_idx] <= saved_lease_q;
        end
    end

    // Default lease, followup bookkeeping, per-set cold counters and full flags.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            default_lease_q <= '0;
            saved_lease_q   <= '0;
            saved_set_q     <= '0;
            followup_q      <= 1'b0;
            full_q          <= '0;
            for (int s = 0; s < N_SETS; s++) cold_cnt_q[s] <= '0;
        end else begin
            if (con_wren_i) default_lease_q <= con_data_i[LBW-1:0];
            if (alloc) begin
                saved_set_q   <= set_i;
                saved_lease_q <= eff_lease;
                followup_q    <= 1'b1;
            end else if (fu_hit) begin
                followup_q <= 1'b0;
            end
            if (gen_en && cold_sel) begin
                cold_cnt_q[saved_set_q] <= cold_cnt_q[saved_set_q] + BW_WAY'(1);
                if (&cold_cnt_q[saved_set_q]) full_q[saved_set_q] <= 1'b1;
            end
        end
    end

    assign done_o          = done_q;
    assign way_o           = way_q;
    assign swap_o          = swap_q;
    assign expired_o       = expired_q;
    assign expired_multi_o = multi_q;
    assign default_o       = default_q;
    assign busy_o          = (state_q == ST_GENERATE);

endmodule

// File: tb/tb_sa_cache_lease_policy_controller.sv
// Bench for sa_cache_lease_policy_controller: two instances (global and
// per-set decrement) share stimulus and are compared to a transaction-level
// model of the lease, cold-fill, expiry and random-victim rules.
`timescale 1ns/1ps
module tb_sa_cache_lease_policy_controller;

    localparam int CAP = 16;
    localparam int SETW = 4;
    localparam int LBW = 24;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        con_wren;
    logic [31:0] con_data;
    logic [1:0]  set_in, way_in;
    logic        hit, miss, lh;
    logic [23:0] lease_in;

    logic       g_done, g_swap, g_exp, g_multi, g_dflt, g_busy;
    logic [1:0] g_way;
    logic       s_done, s_swap, s_exp, s_multi, s_dflt, s_busy;
    logic [1:0] s_way;

    sa_cache_lease_policy_controller #(
        .CACHE_BLOCK_CAPACITY(CAP), .CACHE_SET_SIZE(SETW),
        .LEASE_VALUE_BW(LBW), .DECREMENT_MODE(0)
    ) u_dut_g (
        .clock_i(clk), .reset_i(rst), .con_wren_i(con_wren), .con_data_i(con_data),
        .set_i(set_in), .way_i(way_in), .hit_i(hit), .miss_i(miss),
        .lease_hit_i(lh), .lease_i(lease_in), .done_o(g_done), .way_o(g_way),
        .swap_o(g_swap), .expired_o(g_exp), .expired_multi_o(g_multi),
        .default_o(g_dflt), .busy_o(g_busy)
    );

    sa_cache_lease_policy_controller #(
        .CACHE_BLOCK_CAPACITY(CAP), .CACHE_SET_SIZE(SETW),
        .LEASE_VALUE_BW(LBW), .DECREMENT_MODE(1)
    ) u_dut_s (
        .clock_i(clk), .reset_i(rst), .con_wren_i(con_wren), .con_data_i(con_data),
        .set_i(set_in), .way_i(way_in), .hit_i(hit), .miss_i(miss),
        .lease_hit_i(lh), .lease_i(lease_in), .done_o(s_done), .way_o(s_way),
        .swap_o(s_swap), .expired_o(s_exp), .expired_multi_o(s_multi),
        .default_o(s_dflt), .busy_o(s_busy)
    );

    // Packed view: [7]done [6]swap [5:4]way [3]expired [2]multi [1]default [0]busy
    logic [7:0] obs [2];
    assign obs[0] = {g_done, g_swap, g_way, g_exp, g_multi, g_dflt, g_busy};
    assign obs[1] = {s_done, s_swap, s_way, s_exp, s_multi, s_dflt, s_busy};

    int n_pass = 0;
    int n_total = 0;
    logic [7:0] exp_q[$];

    // ---------------- reference model (index 0: global, 1: per-set) ----------------
    int unsigned m_lease [2][CAP];
    int unsigned m_def [2];
    int unsigned m_cold [2][4];
    bit          m_full [2][4];
    logic [11:0] m_lfsr [2];
    bit          m_fu [2];
    int unsigned m_sset [2];
    int unsigned m_slease [2];
    bit          m_gen [2];
    bit          m_done [2], m_swap [2], m_exp [2], m_multi [2], m_dflt [2];
    logic [1:0]  m_way [2];

    function automatic logic [7:0] exp_out(input int m);
        return {m_done[m], m_swap[m], m_way[m], m_exp[m], m_multi[m], m_dflt[m], m_gen[m]};
    endfunction

    function automatic int unsigned dut_lease(input int m, input int i);
        if (m == 0) return 32'(u_dut_g.lease_q[i]);
        return 32'(u_dut_s.lease_q[i]);
    endfunction

    function automatic logic [11:0] lfsr_next(input logic [11:0] v);
        return {v[10:0], v[11] ^ v[5] ^ v[3] ^ v[0]};
    endfunction

    task automatic model_dec(input int m, input int s);
        for (int i = 0; i < CAP; i++)
            if ((m == 0 || i / SETW == s) && m_lease[m][i] > 0) m_lease[m][i]--;
    endtask

    task automatic model_select(input int m);
        int s, lo, hi;
        s = int'(m_sset[m]);
        if (!m_full[m][s]) begin
            m_way[m] = 2'(m_cold[m][s]);
            if (m_cold[m][s] == 3) m_full[m][s] = 1;
            m_cold[m][s] = (m_cold[m][s] + 1) % 4;
        end else begin
            lo = -1; hi = -1;
            for (int w = 0; w < SETW; w++)
                if (m_lease[m][s*SETW + w] == 0) begin
                    if (lo < 0) lo = w;
                    hi = w;
                end
            if (lo >= 0) begin
                m_way[m] = 2'(lo); m_exp[m] = 1; m_multi[m] = (lo != hi);
            end else begin
                m_way[m] = 2'((m_lfsr[m] >> 1) & 12'd3);
                m_lfsr[m] = lfsr_next(m_lfsr[m]);
            end
        end
    endtask

    task automatic model_step();
        int unsigned l_eff;
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                for (int i = 0; i < CAP; i++) m_lease[m][i] = 0;
                for (int s = 0; s < 4; s++) begin m_cold[m][s] = 0; m_full[m][s] = 0; end
                m_def[m] = 0; m_lfsr[m] = 12'hA11; m_fu[m] = 0; m_sset[m] = 0; m_slease[m] = 0;
                m_gen[m] = 0; m_done[m] = 0; m_swap[m] = 0; m_way[m] = 0;
                m_exp[m] = 0; m_multi[m] = 0; m_dflt[m] = 0;
            end else begin
                l_eff = lh ? 32'(lease_in) : m_def[m];
                m_exp[m] = 0; m_multi[m] = 0; m_dflt[m] = 0;
                if (m_gen[m]) begin
                    model_select(m);
                    m_done[m] = 1; m_gen[m] = 0;
                end else if (miss) begin
                    model_dec(m, int'(set_in));
                    m_dflt[m] = !lh;
                    if (l_eff != 0) begin
                        m_sset[m] = 32'(set_in); m_slease[m] = l_eff; m_fu[m] = 1;
                        m_done[m] = 0; m_swap[m] = 1; m_gen[m] = 1;
                    end else begin
                        m_done[m] = 1; m_swap[m] = 0;
                    end
                end else if (hit) begin
                    if (m_fu[m]) begin
                        m_lease[m][int'(set_in)*SETW + int'(way_in)] = m_slease[m];
                        m_fu[m] = 0;
                    end else begin
                        model_dec(m, int'(set_in));
                        m_lease[m][int'(set_in)*SETW + int'(way_in)] = l_eff;
                        m_dflt[m] = !lh;
                    end
                end
                if (con_wren) m_def[m] = 32'(con_data[23:0]);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        hit = 0; miss = 0; con_wren = 0; lh = 0;
    endtask

    task automatic hit_op(input int s, input int w, input bit l_hit, input int unsigned l);
        set_in = 2'(s); way_in = 2'(w); lh = l_hit; lease_in = 24'(l); hit = 1;
        tick(); idle();
    endtask

    task automatic miss_op(input int s, input bit l_hit, input int unsigned l);
        set_in = 2'(s); lh = l_hit; lease_in = 24'(l); miss = 1;
        tick(); idle();
    endtask

    // allocating miss, generate cycle, then the followup hit on the victim way
    task automatic alloc_follow(input int s, input int unsigned l);
        miss_op(s, 1, l);
        tick();
        hit_op(s, int'(m_way[0]), 0, 0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1; idle(); set_in = 0; way_in = 0; lease_in = 0; con_data = 0;
        tick(); tick();
        rst = 0;
        for (int m = 0; m < 2; m++) begin
            n_total++;
            if (obs[m] !== 8'h00) $display("FAIL reset_outputs m%0d: got %h expected 00", m, obs[m]);
            else n_pass++;
            n_total++;
            begin
                int bad = -1;
                for (int i = 0; i < CAP; i++) if (dut_lease(m, i) != 0) bad = i;
                if (bad >= 0) $display("FAIL reset_leases m%0d: line %0d got %0d expected 0", m, bad, dut_lease(m, bad));
                else n_pass++;
            end
        end
    endtask

    task automatic test_cold_fill();
        for (int k = 0; k < 4; k++) begin
            miss_op(2, 1, 5);
            for (int m = 0; m < 2; m++) begin
                n_total++;
                if (obs[m] !== exp_out(m) || obs[m][7:6] !== 2'b01)
                    $display("FAIL cold_t1 m%0d k%0d: got %h expected %h", m, k, obs[m], exp_out(m));
                else n_pass++;
            end
            tick();
            for (int m = 0; m < 2; m++) begin
                n_total++;
                if (obs[m] !== exp_out(m) || obs[m][5:4] !== 2'(k) || obs[m][7:6] !== 2'b11)
                    $display("FAIL cold_t2 m%0d k%0d: got %h expected %h way %0d", m, k, obs[m], exp_out(m), k);
                else n_pass++;
            end
            hit_op(2, k, 1, 9);
            for (int m = 0; m < 2; m++) begin
                n_total++;
                if (dut_lease(m, 8 + k) != 5)
                    $display("FAIL cold_lease m%0d way%0d: got %0d expected 5", m, k, dut_lease(m, 8 + k));
                else n_pass++;
            end
        end
        n_total++;
        if (u_dut_s.full_q !== 4'b0100) $display("FAIL cold_full: got %b expected 0100", u_dut_s.full_q);
        else n_pass++;
    endtask

    task automatic test_expired();
        for (int k = 0; k < 4; k++) alloc_follow(1, 5);
        hit_op(1, 0, 1, 1);
        hit_op(1, 1, 1, 5);
        hit_op(1, 2, 1, 1);
        hit_op(1, 3, 1, 7);
        miss_op(1, 1, 4);
        begin
            int unsigned want [4] = '{0, 2, 0, 6};
            for (int w = 0; w < 4; w++) begin
                n_total++;
                if (dut_lease(1, 4 + w) != want[w])
                    $display("FAIL expired_dec way%0d: got %0d expected %0d", w, dut_lease(1, 4 + w), want[w]);
                else n_pass++;
            end
        end
        tick();
        for (int m = 0; m < 2; m++) begin
            n_total++;
            if (obs[m] !== 8'hCC || exp_out(m) !== 8'hCC)
                $display("FAIL expired_sel m%0d: got %h expected cc", m, obs[m]);
            else n_pass++;
        end
        hit_op(1, 0, 0, 0);
    endtask

    task automatic test_random_victim();
        for (int w = 0; w < 4; w++) hit_op(1, w, 1, 100);
        for (int r = 0; r < 2; r++) begin
            miss_op(1, 1, 4);
            tick();
            for (int m = 0; m < 2; m++) begin
                exp_q.push_back(exp_out(m));
                n_total++;
                if (obs[m] !== exp_q.pop_front() || obs[m][3] !== 1'b0 || (r == 0 && obs[m][5:4] !== 2'd0))
                    $display("FAIL random_victim m%0d r%0d: got %h expected %h", m, r, obs[m], exp_out(m));
                else n_pass++;
            end
            hit_op(1, int'(m_way[0]), 0, 0);
        end
    endtask

    task automatic test_bypass();
        miss_op(0, 0, 9);
        for (int m = 0; m < 2; m++) begin
            n_total++;
            if (obs[m] !== exp_out(m) || (obs[m] & 8'hC3) !== 8'h82)
                $display("FAIL bypass m%0d: got %h expected %h", m, obs[m], exp_out(m));
            else n_pass++;
        end
        hit_op(0, 1, 1, 3);
        for (int m = 0; m < 2; m++) begin
            int bad = -1;
            for (int i = 0; i < CAP; i++) if (dut_lease(m, i) != m_lease[m][i]) bad = i;
            n_total++;
            if (bad >= 0) $display("FAIL bypass_hit m%0d: line %0d got %0d expected %0d", m, bad, dut_lease(m, bad), m_lease[m][bad]);
            else n_pass++;
        end
    endtask

    task automatic test_scope();
        hit_op(3, 0, 1, 4);
        hit_op(3, 1, 1, 3);
        hit_op(3, 2, 1, 2);
        hit_op(3, 3, 1, 1);
        for (int r = 0; r < 2; r++) begin
            hit_op(0, r, 1, 9);
            for (int w = 0; w < 4; w++) begin
                n_total++;
                if (dut_lease(0, 12 + w) != 0 || dut_lease(1, 12 + w) != 1)
                    $display("FAIL scope r%0d way%0d: got %0d/%0d expected 0/1", r, w, dut_lease(0, 12 + w), dut_lease(1, 12 + w));
                else n_pass++;
            end
        end
    endtask

    task automatic test_con_wren();
        con_wren = 1; con_data = 32'hFF00_0007;
        miss_op(0, 0, 0);
        n_total++;
        if (obs[1] !== exp_out(1) || obs[1][7:6] !== 2'b10)
            $display("FAIL wren_old_default: got %h expected %h", obs[1], exp_out(1));
        else n_pass++;
        miss_op(0, 0, 0);
        n_total++;
        if (obs[1] !== exp_out(1) || obs[1][7:6] !== 2'b01)
            $display("FAIL wren_new_default: got %h expected %h", obs[1], exp_out(1));
        else n_pass++;
        tick();
        hit_op(0, int'(m_way[1]), 1, 2);
        n_total++;
        if (dut_lease(1, int'(m_way[1])) != 7)
            $display("FAIL wren_followup: got %0d expected 7", dut_lease(1, int'(m_way[1])));
        else n_pass++;
    endtask

    task automatic test_reset_generate();
        miss_op(2, 1, 5);
        rst = 1;
        tick();
        rst = 0;
        for (int m = 0; m < 2; m++) begin
            n_total++;
            if (obs[m] !== 8'h00 || exp_out(m) !== 8'h00)
                $display("FAIL reset_gen m%0d: got %h expected 00", m, obs[m]);
            else n_pass++;
        end
        miss_op(2, 1, 5);
        tick();
        for (int m = 0; m < 2; m++) begin
            n_total++;
            if (obs[m] !== exp_out(m) || obs[m][5:4] !== 2'd0 || obs[m][7:6] !== 2'b11)
                $display("FAIL reset_gen_cold m%0d: got %h expected %h", m, obs[m], exp_out(m));
            else n_pass++;
        end
        hit_op(2, 0, 0, 0);
    endtask

    task automatic test_random_traffic();
        for (int it = 0; it < 300; it++) begin
            int kind;
            kind = $urandom_range(0, 9);
            set_in = 2'($urandom_range(0, 3));
            way_in = 2'($urandom_range(0, 3));
            lh = 1'($urandom_range(0, 1));
            lease_in = 24'($urandom_range(0, 6));
            con_wren = ($urandom_range(0, 7) == 0);
            con_data = $urandom_range(0, 5);
            if (kind < 4) begin
                miss = 1; hit = ($urandom_range(0, 3) == 0);
            end else begin
                hit = 1;
            end
            tick(); idle();
            for (int m = 0; m < 2; m++) begin
                n_total++;
                if (obs[m] !== exp_out(m)) $display("FAIL traffic it%0d m%0d: got %h expected %h", it, m, obs[m], exp_out(m));
                else n_pass++;
            end
            if (m_gen[0] || m_gen[1]) begin
                hit = 1'($urandom_range(0, 1)); miss = 1'($urandom_range(0, 1));
                set_in = 2'($urandom_range(0, 3)); lh = 1;
                tick(); idle();
                for (int m = 0; m < 2; m++) begin
                    n_total++;
                    if (obs[m] !== exp_out(m)) $display("FAIL traffic_gen it%0d m%0d: got %h expected %h", it, m, obs[m], exp_out(m));
                    else n_pass++;
                end
            end
            if (it % 25 == 0) begin
                for (int m = 0; m < 2; m++) begin
                    int bad = -1;
                    for (int i = 0; i < CAP; i++) if (dut_lease(m, i) != m_lease[m][i]) bad = i;
                    n_total++;
                    if (bad >= 0) $display("FAIL traffic_lease it%0d m%0d: line %0d got %0d expected %0d", it, m, bad, dut_lease(m, bad), m_lease[m][bad]);
                    else n_pass++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_cold_fill();
        test_expired();
        test_random_victim();
        test_bypass();
        test_scope();
        test_con_wren();
        test_reset_generate();
        test_random_traffic();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
